counter_ctrl: RTL
=================

// Module: counter_ctrl
// PURPOSE
//  Run/pause/clear sequencer for the 00..19 two-digit BCD counter.
//  - Debounces two raw push-buttons and runs a start/pause/clear FSM.
//  - Produces the counter's pause_state level, a 1-cycle count-enable tick from a prescaler,
//    and a 1-cycle synchronous clear pulse.
//  - Sits between the board keys and the counter; reads the counter digits back for terminal-count detection.
// PARAMETERS
//  DB_CYCLES    1_000_000   clk cycles a key must be stable before the new level is accepted (20 ms @ 50 MHz)
//  TICK_CYCLES  50_000_000  clk cycles between count ticks while RUN (1 Hz @ 50 MHz)
// PORTS
//  clk          in   1  system clock; all logic on posedge
//  rst          in   1  synchronous, active-high reset
//  key_start    in   1  raw start/pause button, active-high, asynchronous to clk
//  key_clr      in   1  raw clear button, active-high, asynchronous to clk
//  cnt_ones     in   4  counter ones digit (BCD 0..9)
//  cnt_tens     in   4  counter tens digit (0..1)
//  pause_state  out  1  high = counter must hold; low only in RUN
//  cnt_tick     out  1  1-cycle count enable, asserted only in RUN
//  cnt_clr      out  1  1-cycle clear request to counter
//  state        out  2  FSM state: IDLE=00, RUN=01, PAUSE=10, DONE=11
// BEHAVIOUR
//  Reset (rst=1 at posedge):
//   - state=IDLE, pause_state=1, cnt_tick=0, cnt_clr=0.
//   - Prescaler=0, debounce counters=0, sync/debounced key levels=0.
//  Key path, per key:
//   - 2-FF synchronizer, then debounce counter.
//   - Counter resets whenever the synced level equals the accepted level.
//   - When the synced level has differed for DB_CYCLES consecutive cycles, the accepted level takes the synced level.
//   - press = 1-cycle pulse on the accepted level's 0->1 transition; key release produces no event.
//   - Latency from raw edge (held stable) to press pulse: 2 + DB_CYCLES cycles.
//  FSM: state updates on the cycle after the press pulse. Transitions:
//   - clr_press, any state -> IDLE; cnt_clr=1 for exactly that cycle.
//   - start_press: IDLE->RUN, RUN->PAUSE, PAUSE->RUN; ignored in DONE.
//   - clr_press and start_press in the same cycle: clear wins, start is discarded.
//  Prescaler:
//   - RUN: counts 0..TICK_CYCLES-1 and wraps.
//   - PAUSE: holds its value, so the tick phase is preserved on resume.
//   - IDLE/DONE: forced to 0.
//  Outputs:
//   - cnt_tick=1 for one cycle when the prescaler is at TICK_CYCLES-1 and state=RUN.
//   - First tick after IDLE->RUN arrives TICK_CYCLES cycles after entering RUN.
//   - A pause on the same cycle as a wrap suppresses that tick; the prescaler keeps the value TICK_CYCLES-1.
//   - pause_state = (state!=RUN), registered together with state; no glitches.
//  Counter contract: the counter is assumed to count 00..19 and wrap to 00 itself; this block never drives digits.
// CONFIGURATION
//  AUTO_STOP_EN defined:
//   - In RUN, when a tick would fire while cnt_tens==1 and cnt_ones==9, the tick is suppressed and state->DONE.
//   - Counter stays at 19. DONE holds pause_state=1 and ignores start; only clr exits (->IDLE).
//  AUTO_STOP_EN undefined:
//   - Counter free-runs and wraps 19->00. DONE is unreachable.
//   - Digit inputs are unused; the tool may trim them.
// TESTING (bench uses DB_CYCLES=4, TICK_CYCLES=10)
//  1. rst=1 for 2 cycles -> state=00, pause_state=1, cnt_tick=0, cnt_clr=0; no ticks over the next 100 cycles.
//  2. key_start high 20 cycles -> state=01 exactly 2+4+1 cycles after the raw edge.
//     Then cnt_tick pulses every 10 cycles; pause_state=0.
//  3. key_start glitch high 3 cycles, low 10 -> no press, state unchanged.
//     Second press in RUN -> PAUSE, ticks stop; third press -> RUN, next tick keeps the prescaler phase.
//  4. key_start and key_clr raised on the same cycle while in RUN -> one cnt_clr pulse, state=IDLE, prescaler=0.
//  5. AUTO_STOP_EN with digits driven 1/9 in RUN -> at the wrap cycle cnt_tick stays 0 and state=11.
//     Start press ignored; clr press -> IDLE plus one cnt_clr.
//  6. Without AUTO_STOP_EN, same stimulus -> cnt_tick=1 at the wrap cycle, state stays 01.

Source files
------------

// File: rtl/counter_ctrl.sv
// Run/pause/clear sequencer for the 00..19 BCD counter: key debounce, control FSM, tick prescaler.
// Optional feature: define AUTO_STOP_EN to stop in DONE when a tick would wrap the counter past 19.
module counter_ctrl #(
  parameter int DB_CYCLES   = 1_000_000,
  parameter int TICK_CYCLES = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_start,
  input  logic       key_clr,
  input  logic [3:0] cnt_ones,
  input  logic [3:0] cnt_tens,
  output logic       pause_state,
  output logic       cnt_tick,
  output logic       cnt_clr,
  output logic [1:0] state
);

  localparam int DB_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam int TK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);
  localparam logic [TK_W-1:0] TK_LAST = TK_W'(TICK_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    DONE  = 2'b11
  } state_t;

  // Bit 0 is the start key, bit 1 the clear key.
  logic [1:0] key_raw;
  logic [1:0] press;

  assign key_raw = {key_clr, key_start};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_key
      logic            sync1_reg;
      logic            sync2_reg;
      logic            level_reg;
      logic            level_d_reg;
      logic [DB_W-1:0] db_cnt_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          sync1_reg   <= 1'b0;
          sync2_reg   <= 1'b0;
          level_reg   <= 1'b0;
          level_d_reg <= 1'b0;
          db_cnt_reg  <= '0;
        end else begin
          sync1_reg   <= key_raw[gi];
          sync2_reg   <= sync1_reg;
          level_d_reg <= level_reg;
          // Accept the new level only after DB_CYCLES consecutive differing samples.
          if (sync2_reg == level_reg) begin
            db_cnt_reg <= '0;
          end else if (db_cnt_reg == DB_LAST) begin
            level_reg  <= sync2_reg;
            db_cnt_reg <= '0;
          end else begin
            db_cnt_reg <= db_cnt_reg + DB_W'(1);
          end
        end
      end

      assign press[gi] = level_reg & ~level_d_reg;
    end
  endgenerate

  logic start_press;
  logic clr_press;

  assign start_press = press[0];
  assign clr_press   = press[1];

  state_t          state_reg, state_next;
  logic            pause_reg, pause_next;
  logic            tick_reg, tick_next;
  logic            clr_reg, clr_next;
  logic [TK_W-1:0] presc_reg, presc_next;
  logic            at_wrap;
  logic            stop_hit;

  assign at_wrap = (presc_reg == TK_LAST);

`ifdef AUTO_STOP_EN
  assign stop_hit = at_wrap && (cnt_tens == 4'd1) && (cnt_ones == 4'd9);
`else
  logic unused_digits;
  assign unused_digits = ^{cnt_tens, cnt_ones};
  assign stop_hit      = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      pause_reg <= 1'b1;
      tick_reg  <= 1'b0;
      clr_reg   <= 1'b0;
      presc_reg <= '0;
    end else begin
      state_reg <= state_next;
      pause_reg <= pause_next;
      tick_reg  <= tick_next;
      clr_reg   <= clr_next;
      presc_reg <= presc_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    clr_next   = 1'b0;
    presc_next = '0;

    if (clr_press) begin
      state_next = IDLE;
      clr_next   = 1'b1;
    end else begin
      case (state_reg)
        IDLE:    if (start_press) state_next = RUN;
        RUN: begin
          if (start_press)   state_next = PAUSE;
          else if (stop_hit) state_next = DONE;
        end
        PAUSE:   if (start_press) state_next = RUN;
        default: state_next = state_reg;
      endcase
    end

    // The prescaler only advances on cycles spent fully in RUN, so a pause
    // on the wrap cycle keeps TICK_CYCLES-1 and fires right after resume.
    case (state_next)
      RUN:     presc_next = (state_reg != RUN) ? presc_reg :
                            (at_wrap ? '0 : presc_reg + TK_W'(1));
      PAUSE:   presc_next = presc_reg;
      default: presc_next = '0;
    endcase

    tick_next  = (state_reg == RUN) && (state_next == RUN) && at_wrap;
    pause_next = (state_next != RUN);
  end

  assign state       = state_reg;
  assign pause_state = pause_reg;
  assign cnt_tick    = tick_reg;
  assign cnt_clr     = clr_reg;

endmodule
